// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and helpers for the sequential radix-2 divider.
//            - div_state_t       : controller states (IDLE -> ITER -> FIX)
//            - DIV_WIDTH_DEFAULT : default operand width
//            - div_cnt_w()       : width of the iteration counter for WIDTH
// Revision : 1.0  initial release
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One restoring-division iteration (purely combinational).
//            {rem,quo} is shifted left by one; the divisor magnitude is
//            trial-subtracted from the widened partial remainder and the new
//            quotient bit is shifted into quo[0].
// Ports    : rem_i          partial remainder in
//            quo_i          partial quotient / remaining dividend bits in
//            divisor_mag_i  unsigned divisor magnitude
//            rem_o, quo_o   values after this iteration
// Revision : 1.0  initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_mag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One extra bit so a divisor magnitude of 2^(WIDTH-1) (|MIN|) never
  // overflows the shifted remainder.
  logic [WIDTH:0] shifted_w;
  logic [WIDTH:0] trial_w;

  always_comb begin
    shifted_w = {rem_i, quo_i[WIDTH-1]};
    trial_w   = shifted_w - {1'b0, divisor_mag_i};
    if (trial_w[WIDTH]) begin
      // Borrow: restore, quotient bit 0.
      rem_o = shifted_w[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial_w[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle radix-2 restoring divider, signed (DIV) or unsigned
//            (DIVU), with start/busy/done handshake. Quotient -> LO,
//            remainder -> HI. Signed results truncate toward zero and the
//            remainder takes the dividend's sign.
// Ports    : clk, rst_n (async active-low)
//            start, is_signed, dividend, divisor : request, sampled in IDLE
//            busy        : operation in flight
//            done        : one-cycle result-valid pulse
//            quotient, remainder, div_by_zero : held until the next result
// Options  : SEQ_DIV_EARLY_OUT_EN - when defined, a zero divisor or a divisor
//            magnitude larger than the dividend magnitude skips the iteration
//            phase (done two edges after start). Undefined: fixed latency of
//            WIDTH+2 edges for every operand pair.
// Revision : 1.0  initial release
// ============================================================================
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             dneg_q, dneg_d;      // dividend was negative (signed op)
  logic             sneg_q, sneg_d;      // divisor was negative (signed op)
  logic             zero_q, zero_d;      // divisor was zero
  logic [WIDTH-1:0] dvd_q, dvd_d;        // original dividend for div-by-zero
  logic [WIDTH-1:0] dmag_q, dmag_d;      // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;        // partial quotient / dividend bits
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dvd_mag_w;
  logic [WIDTH-1:0] dvs_mag_w;
  logic [WIDTH-1:0] step_rem_w;
  logic [WIDTH-1:0] step_quo_w;

  // |MIN| wraps to MIN, which is the correct unsigned magnitude.
  assign dvd_mag_w = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag_w = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(
    .WIDTH         (WIDTH)
  ) u_step (
    .rem_i         (rem_q),
    .quo_i         (quo_q),
    .divisor_mag_i (dmag_q),
    .rem_o         (step_rem_w),
    .quo_o         (step_quo_w)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    dneg_d      = dneg_q;
    sneg_d      = sneg_q;
    zero_d      = zero_q;
    dvd_d       = dvd_q;
    dmag_d      = dmag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          signed_d = is_signed;
          dneg_d   = is_signed & dividend[WIDTH-1];
          sneg_d   = is_signed & divisor[WIDTH-1];
          zero_d   = (divisor == '0);
          dvd_d    = dividend;
          dmag_d   = dvs_mag_w;
          rem_d    = '0;
          quo_d    = dvd_mag_w;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = DIV_ITER;
`ifdef SEQ_DIV_EARLY_OUT_EN
          // Result is already known: quotient 0, remainder = dividend
          // magnitude (FIX restores the sign; zero divisor is forced there).
          if ((divisor == '0) || (dvs_mag_w > dvd_mag_w)) begin
            rem_d   = dvd_mag_w;
            quo_d   = '0;
            state_d = DIV_FIX;
          end
`endif
        end
      end

      DIV_ITER: begin
        rem_d = step_rem_w;
        quo_d = step_quo_w;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DIV_FIX;
        end
      end

      DIV_FIX: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else begin
          quotient_d  = (signed_q && (dneg_q != sneg_q)) ? -quo_q : quo_q;
          remainder_d = (signed_q && dneg_q) ? -rem_q : rem_q;
        end
        dbz_d   = zero_q;
        done_d  = 1'b1;
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      dneg_q      <= 1'b0;
      sneg_q      <= 1'b0;
      zero_q      <= 1'b0;
      dvd_q       <= '0;
      dmag_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      signed_q    <= signed_d;
      dneg_q      <= dneg_d;
      sneg_q      <= sneg_d;
      zero_q      <= zero_d;
      dvd_q       <= dvd_d;
      dmag_q      <= dmag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != DIV_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle radix-2 restoring divider; the next generation after the single-cycle combinational signed divider.
- Produces quotient and remainder in both signed and unsigned mode, and flags divide-by-zero.
- Uses a start/busy/done handshake so the MIPS core can stall on DIV/DIVU and write HI (remainder) and LO (quotient).

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = two's-complement (DIV), 0 = unsigned (DIVU); sampled with start
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  result (LO)
- remainder  output  WIDTH  result (HI)
- div_by_zero  output  1  divisor was zero for the last completed operation

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; iteration counter=0. Reset mid-operation aborts with no done pulse.
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE, start=1 at edge k:
  - Latch is_signed, sign of dividend, sign of divisor.
  - Latch |dividend| and |divisor|; magnitudes are taken only when is_signed=1.
  - Clear partial remainder; counter=WIDTH; busy=1 from edge k.
- ITER, one quotient bit per cycle, MSB first:
  - Shift {rem,quo} left by 1; trial = rem - divisor_mag.
  - If trial is non-negative, rem=trial and quo[0]=1.
  - Decrement counter; at count 1 go to FIX (WIDTH cycles in ITER).
- FIX, single cycle:
  - Negate quotient if is_signed and signs differ; negate remainder if is_signed and dividend was negative (truncate toward zero, remainder takes dividend's sign).
  - Register quotient, remainder, div_by_zero; done=1; busy=0; next state IDLE.
- Latency: done asserted in the cycle after edge k+WIDTH+1 (WIDTH+2 edges after start sample); busy high for edges k..k+WIDTH+1.
- Outputs hold their values until the next FIX. done is exactly one cycle wide.
- start while busy is ignored and does not queue. start in the same cycle done is high is accepted (back-to-back allowed).
- Divide by zero: quotient all-ones, remainder = original dividend (unmodified), div_by_zero=1. This falls out of the algorithm for unsigned mode; FIX forces the same values for signed mode.
- Signed overflow (MIN / -1): quotient=MIN, remainder=0; no flag.
- Internal datapath is WIDTH+1 bits for trial subtraction so that |MIN| is handled as a WIDTH-bit unsigned magnitude.

Optional Feature:
- SEQ_DIV_EARLY_OUT_EN defined: in IDLE on start, if divisor=0 or divisor_mag > dividend_mag, skip ITER and go straight to FIX. FIX produces quotient=0, remainder=dividend, or the divide-by-zero values. done arrives 2 edges after the start sample.
- Undefined: latency is a fixed WIDTH+2 for every operand pair, including divide-by-zero.

Decomposition:
- Shared package div_pkg:
  - typedef enum logic [1:0] div_state_t {DIV_IDLE, DIV_ITER, DIV_FIX};
  - localparam DIV_WIDTH_DEFAULT=32;
  - function div_cnt_w(WIDTH) returning $clog2(WIDTH+1).
- One combinational sub-module, div_step: one restoring iteration. Inputs rem, quo, divisor_mag; outputs next rem and next quo. Keeps the top-level FSM separate from the arithmetic.

Test Plan:
- Unsigned 8/4, is_signed=0 -> quotient=2, remainder=0; done exactly 34 edges after start, busy high 33 cycles.
- Signed -7/2 -> quotient=-3 (0xFFFFFFFD), remainder=-1. Signed 7/-2 -> quotient=-3, remainder=1. Signed -6/-2 -> quotient=3, remainder=0.
- Unsigned 0xFFFFFFFF/2 -> quotient=0x7FFFFFFF, remainder=1. Same operands signed -> quotient=0, remainder=-1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Then 123/0 -> quotient=0xFFFFFFFF, remainder=123, div_by_zero=1.
- Second start pulsed mid-operation is ignored (result matches first operands). start in the done cycle is accepted, with done again 34 edges later.
- rst_n low at iteration 10 -> busy, done and outputs go 0 immediately, no done pulse. With SEQ_DIV_EARLY_OUT_EN, 3/10 -> done 2 edges after start, quotient=0, remainder=3.
